// File: rtl/p405s_ldsteerqueue.sv
// Load-steer descriptor queue: holds WB steering descriptors in issue order
// until their load data returns, with same-cycle bypass, flush and sticky
// overflow/underflow flags.
module p405s_ldsteerqueue #(
  parameter int DEPTH  = 4,
  parameter int DESC_W = 20,
  parameter int CNT_W  = 3
) (
  input  logic              CB,
  input  logic              rstL,
  input  logic              wbLdPush,
  input  logic [DESC_W-1:0] wbLdDesc,
  input  logic              ldDataRtn,
  input  logic              qFlush,
  input  logic              errClr,
  output logic [DESC_W-1:0] steerSel,
  output logic              steerSelVld,
  output logic              qEmpty,
  output logic              qFull,
  output logic [CNT_W-1:0]  qCount,
  output logic              qOvf,
  output logic              qUnf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0][DESC_W-1:0] entry;
  logic [PTR_W-1:0]             rdPtr, wrPtr;
  logic [PTR_W-1:0]             rdPtrNxt, wrPtrNxt;
  logic                         bypass, doWrite, doPop, ovfSet, unfSet;

  assign qEmpty = (qCount == '0);
  assign qFull  = (qCount == CNT_FULL);

  // Empty queue with push and return together: hand the descriptor straight through.
  assign bypass = qEmpty & wbLdPush & ldDataRtn;

  // A pop on a non-empty queue frees a slot, so a coincident push is legal even when full.
  assign doWrite = wbLdPush & ~qFlush & (ldDataRtn ? ~qEmpty : ~qFull);
  assign doPop   = ldDataRtn & ~qFlush & ~qEmpty;
  assign ovfSet  = wbLdPush & ~ldDataRtn & qFull & ~qFlush;
  assign unfSet  = ldDataRtn & ~wbLdPush & qEmpty & ~qFlush;

  // Explicit wrap so non-power-of-2 depths work.
  assign rdPtrNxt = (rdPtr == PTR_LAST) ? '0 : rdPtr + PTR_W'(1);
  assign wrPtrNxt = (wrPtr == PTR_LAST) ? '0 : wrPtr + PTR_W'(1);

  // Head descriptor (or bypassed push); zero when nothing is available.
  always_comb begin
    steerSel = '0;
    if (bypass)       steerSel = wbLdDesc;
    else if (!qEmpty) steerSel = entry[rdPtr];
  end

  assign steerSelVld = ldDataRtn & (~qEmpty | wbLdPush);

  // Pointer and occupancy update; flush overrides everything.
  always_ff @(posedge CB or negedge rstL) begin
    if (!rstL) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      qCount <= '0;
    end else if (qFlush) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      qCount <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtrNxt;
      if (doPop)   rdPtr <= rdPtrNxt;
      if (doWrite && !doPop)      qCount <= qCount + CNT_W'(1);
      else if (doPop && !doWrite) qCount <= qCount - CNT_W'(1);
    end
  end

  // Descriptor storage, written at the tail.
  always_ff @(posedge CB or negedge rstL) begin
    if (!rstL) begin
      entry <= '0;
    end else if (doWrite) begin
      for (int i = 0; i < DEPTH; i++)
        if (wrPtr == PTR_W'(i)) entry[i] <= wbLdDesc;
    end
  end

  // Sticky error flags; a new set event beats a coincident clear.
  always_ff @(posedge CB or negedge rstL) begin
    if (!rstL) begin
      qOvf <= 1'b0;
      qUnf <= 1'b0;
    end else begin
      if (ovfSet)      qOvf <= 1'b1;
      else if (errClr) qOvf <= 1'b0;
      if (unfSet)      qUnf <= 1'b1;
      else if (errClr) qUnf <= 1'b0;
    end
  end

endmodule
